uart_csr_arbiter: RTL

- Shares the single UART CSR port (csr_a/csr_we/csr_di/csr_do) between two bus requesters, m0 (host CPU) and m1 (test/DMA sequencer).
- Round-robin arbitration; one transaction in flight; optional lock for atomic read-modify-write.
- Owns the UART read-latency timing so requesters see a simple req/ack handshake.
- Sits between the requesters and the UART core's CSR inputs.

---
 rtl/uart_csr_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_csr_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : uart_csr_arbiter
// Brief    : Round-robin two-master arbiter onto the UART CSR port, with lock
//            support and fixed UART read-latency handling.
// Revision : 1.0
// =============================================================================
module uart_csr_arbiter #(
    parameter int CSR_AW   = 14,
    parameter int CSR_DW   = 32,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [CSR_AW-1:0] m0_a,
    input  logic [CSR_DW-1:0] m0_di,
    input  logic              m0_lock,
    output logic              m0_ack,
    output logic [CSR_DW-1:0] m0_do,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [CSR_AW-1:0] m1_a,
    input  logic [CSR_DW-1:0] m1_di,
    input  logic              m1_lock,
    output logic              m1_ack,
    output logic [CSR_DW-1:0] m1_do,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [CSR_DW-1:0] csr_di,
    input  logic [CSR_DW-1:0] csr_do,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic [2:0] c_WCNT_LAST = 3'(RD_LAT - 1);
    localparam logic [4:0] c_LOCK_MAX  = 5'(LOCK_MAX);

    state_t              r_state,      w_state_nxt;
    logic                r_sel,        w_sel_nxt;
    logic                r_we,         w_we_nxt;
    logic [CSR_AW-1:0]   r_a,          w_a_nxt;
    logic [CSR_DW-1:0]   r_di,         w_di_nxt;
    logic [2:0]          r_wcnt,       w_wcnt_nxt;
    logic                r_last_gnt,   w_last_nxt;
    logic                r_lock_vld,   w_lock_vld_nxt;
    logic                r_lock_id,    w_lock_id_nxt;
    logic [3:0]          r_lock_cnt,   w_lock_cnt_nxt;
    logic [CSR_AW-1:0]   r_csr_a,      w_csr_a_nxt;
    logic                r_csr_we,     w_csr_we_nxt;
    logic [CSR_DW-1:0]   r_csr_di,     w_csr_di_nxt;
    logic                r_m0_ack,     w_m0_ack_nxt;
    logic                r_m1_ack,     w_m1_ack_nxt;
    logic [CSR_DW-1:0]   r_m0_do,      w_m0_do_nxt;
    logic [CSR_DW-1:0]   r_m1_do,      w_m1_do_nxt;
    logic                r_busy,       w_busy_nxt;

    logic                w_cand0;
    logic                w_cand1;
    logic                w_pick;
    logic                w_we_pick;
    logic [CSR_AW-1:0]   w_a_pick;
    logic [CSR_DW-1:0]   w_di_pick;
    logic                w_lock_req;
    logic [4:0]          w_lock_inc;
    logic [CSR_DW-1:0]   w_cap;

    // While a lock is held only the owner may be granted.
    assign w_cand0    = m0_req & (~r_lock_vld | ~r_lock_id);
    assign w_cand1    = m1_req & (~r_lock_vld |  r_lock_id);
    assign w_pick     = (w_cand0 & w_cand1) ? ~r_last_gnt : w_cand1;
    assign w_we_pick  = w_pick ? m1_we : m0_we;
    assign w_a_pick   = w_pick ? m1_a  : m0_a;
    assign w_di_pick  = w_pick ? m1_di : m0_di;
    assign w_lock_req = r_sel ? m1_lock : m0_lock;
    assign w_lock_inc = {1'b0, r_lock_cnt} + 5'd1;
    assign w_cap      = r_we ? '0 : csr_do;

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_we_nxt       = r_we;
        w_a_nxt        = r_a;
        w_di_nxt       = r_di;
        w_wcnt_nxt     = r_wcnt;
        w_last_nxt     = r_last_gnt;
        w_lock_vld_nxt = r_lock_vld;
        w_lock_id_nxt  = r_lock_id;
        w_lock_cnt_nxt = r_lock_cnt;
        w_csr_a_nxt    = '0;
        w_csr_we_nxt   = 1'b0;
        w_csr_di_nxt   = '0;
        w_m0_ack_nxt   = 1'b0;
        w_m1_ack_nxt   = 1'b0;
        w_m0_do_nxt    = '0;
        w_m1_do_nxt    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_cand0 || w_cand1) begin
                    w_state_nxt  = S_ISSUE;
                    w_sel_nxt    = w_pick;
                    w_we_nxt     = w_we_pick;
                    w_a_nxt      = w_a_pick;
                    w_di_nxt     = w_di_pick;
                    w_csr_a_nxt  = w_a_pick;
                    w_csr_di_nxt = w_di_pick;
                    w_csr_we_nxt = w_we_pick;
                end
            end
            S_ISSUE: begin
                w_state_nxt  = S_WAIT;
                w_wcnt_nxt   = '0;
                w_csr_a_nxt  = r_a;
                w_csr_di_nxt = r_di;
            end
            S_WAIT: begin
                if (r_wcnt == c_WCNT_LAST) begin
                    w_state_nxt  = S_ACK;
                    w_m0_ack_nxt = ~r_sel;
                    w_m1_ack_nxt = r_sel;
                    if (r_sel) begin
                        w_m1_do_nxt = w_cap;
                    end else begin
                        w_m0_do_nxt = w_cap;
                    end
                end else begin
                    w_wcnt_nxt   = r_wcnt + 3'd1;
                    w_csr_a_nxt  = r_a;
                    w_csr_di_nxt = r_di;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
                w_last_nxt  = r_sel;
                if (w_lock_req && (w_lock_inc < c_LOCK_MAX)) begin
                    w_lock_vld_nxt = 1'b1;
                    w_lock_id_nxt  = r_sel;
                    w_lock_cnt_nxt = w_lock_inc[3:0];
                end else begin
                    w_lock_vld_nxt = 1'b0;
                    w_lock_id_nxt  = 1'b0;
                    w_lock_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 1'b0;
            r_we       <= 1'b0;
            r_a        <= '0;
            r_di       <= '0;
            r_wcnt     <= '0;
            r_last_gnt <= 1'b1;
            r_lock_vld <= 1'b0;
            r_lock_id  <= 1'b0;
            r_lock_cnt <= '0;
            r_csr_a    <= '0;
            r_csr_we   <= 1'b0;
            r_csr_di   <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
            r_m0_do    <= '0;
            r_m1_do    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_we       <= w_we_nxt;
            r_a        <= w_a_nxt;
            r_di       <= w_di_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_last_gnt <= w_last_nxt;
            r_lock_vld <= w_lock_vld_nxt;
            r_lock_id  <= w_lock_id_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
            r_csr_a    <= w_csr_a_nxt;
            r_csr_we   <= w_csr_we_nxt;
            r_csr_di   <= w_csr_di_nxt;
            r_m0_ack   <= w_m0_ack_nxt;
            r_m1_ack   <= w_m1_ack_nxt;
            r_m0_do    <= w_m0_do_nxt;
            r_m1_do    <= w_m1_do_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign m0_ack = r_m0_ack;
    assign m1_ack = r_m1_ack;
    assign m0_do  = r_m0_do;
    assign m1_do  = r_m1_do;
    assign csr_a  = r_csr_a;
    assign csr_we = r_csr_we;
    assign csr_di = r_csr_di;
    assign busy   = r_busy;

endmodule
`default_nettype wire
